bp_tournament_local: RTL and testbench

BP_TOURNAMENT_LOCAL -- requirements
Module: bp_tournament_local

---
 rtl/mips_core_pkg.sv | 31 +++
 rtl/bp_tournament_local_if.sv | 56 +++++
 rtl/sat_counter_update.sv | 33 +++
 rtl/bp_tournament_local.sv | 235 +++++++++++++++++++++++
 tb/tb_bp_tournament_local.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: branch direction, address width, predictor bookkeeping
// record and the tournament predictor's controller state encoding.
package mips_core_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  // Default history widths of the tournament predictor, used to size the
  // per-branch record a pipeline carries from lookup to commit.
  localparam int TL_GHIST_BITS = 8;
  localparam int TL_LHIST_BITS = 6;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    pc;
    logic [TL_GHIST_BITS-1:0] ghistory;
    logic [TL_LHIST_BITS-1:0] lhistory;
    BranchOutcome             prediction;
    BranchOutcome             pred_global;
    BranchOutcome             pred_local;
  } bp_tl_info;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } bp_tl_state_e;

endpackage

// File: rtl/bp_tournament_local_if.sv
// Lookup/feedback bundle of the tournament predictor. The master side issues
// lookups and commits; the slave side is the predictor.
// Optional statistics outputs exist only when BP_STATS_EN is defined.
interface bp_tournament_local_if
  import mips_core_pkg::*;
#(
  parameter int GHIST_BITS = 8,
  parameter int LHIST_BITS = 6
) ();

  logic                  i_req_valid;
  logic [ADDR_WIDTH-1:0] i_req_pc;
  logic                  o_req_ready;
  BranchOutcome          o_req_prediction;
  BranchOutcome          o_req_pred_global;
  BranchOutcome          o_req_pred_local;
  logic [GHIST_BITS-1:0] o_req_ghistory;
  logic [LHIST_BITS-1:0] o_req_lhistory;

  logic                  i_fb_valid;
  logic [ADDR_WIDTH-1:0] i_fb_pc;
  logic [GHIST_BITS-1:0] i_fb_ghistory;
  logic [LHIST_BITS-1:0] i_fb_lhistory;
  BranchOutcome          i_fb_prediction;
  BranchOutcome          i_fb_pred_global;
  BranchOutcome          i_fb_pred_local;
  BranchOutcome          i_fb_outcome;

`ifdef BP_STATS_EN
  logic [31:0]           o_stat_branches;
  logic [31:0]           o_stat_mispredicts;
`endif

  modport master (
    output i_req_valid, i_req_pc,
    input  o_req_ready, o_req_prediction, o_req_pred_global, o_req_pred_local,
    input  o_req_ghistory, o_req_lhistory,
    output i_fb_valid, i_fb_pc, i_fb_ghistory, i_fb_lhistory,
    output i_fb_prediction, i_fb_pred_global, i_fb_pred_local, i_fb_outcome
`ifdef BP_STATS_EN
    , input o_stat_branches, o_stat_mispredicts
`endif
  );

  modport slave (
    input  i_req_valid, i_req_pc,
    output o_req_ready, o_req_prediction, o_req_pred_global, o_req_pred_local,
    output o_req_ghistory, o_req_lhistory,
    input  i_fb_valid, i_fb_pc, i_fb_ghistory, i_fb_lhistory,
    input  i_fb_prediction, i_fb_pred_global, i_fb_pred_local, i_fb_outcome
`ifdef BP_STATS_EN
    , output o_stat_branches, o_stat_mispredicts
`endif
  );

endinterface

// File: rtl/sat_counter_update.sv
// Next value of a saturating up/down counter: +1 toward all-ones, -1 toward
// zero, holding at either rail.
module sat_counter_update #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                up_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE = {{(CTR_BITS-1){1'b0}}, 1'b1};

  // Saturating increment on up, saturating decrement otherwise
  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != CTR_MAX) begin
        ctr_o = ctr_i + CTR_ONE;
      end else begin
        ctr_o = ctr_i;
      end
    end else begin
      if (ctr_i != CTR_MIN) begin
        ctr_o = ctr_i - CTR_ONE;
      end else begin
        ctr_o = ctr_i;
      end
    end
  end

endmodule

// File: rtl/bp_tournament_local.sv
// Tournament branch predictor: gshare global component, per-PC local-history
// component and a gshare-indexed chooser. After reset the controller sweeps
// every table to its initial value before accepting lookups.
// Optional feature macro: BP_STATS_EN adds branch/mispredict counters.
module bp_tournament_local
  import mips_core_pkg::*;
#(
  parameter int GHIST_BITS  = 8,
  parameter int LHIST_BITS  = 6,
  parameter int LHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_req_ready,
  output BranchOutcome          o_req_prediction,
  output BranchOutcome          o_req_pred_global,
  output BranchOutcome          o_req_pred_local,
  output logic [GHIST_BITS-1:0] o_req_ghistory,
  output logic [LHIST_BITS-1:0] o_req_lhistory,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic [GHIST_BITS-1:0] i_fb_ghistory,
  input  logic [LHIST_BITS-1:0] i_fb_lhistory,
  input  BranchOutcome          i_fb_prediction,
  input  BranchOutcome          i_fb_pred_global,
  input  BranchOutcome          i_fb_pred_local,
  input  BranchOutcome          i_fb_outcome
`ifdef BP_STATS_EN
  ,
  output logic [31:0]           o_stat_branches,
  output logic [31:0]           o_stat_mispredicts
`endif
);

  localparam int GDEPTH  = 1 << GHIST_BITS;
  localparam int LDEPTH  = 1 << LHIST_BITS;
  localparam int LHT_IDX = $clog2(LHT_ENTRIES);
  localparam int MAXD_GL = (GDEPTH > LDEPTH) ? GDEPTH : LDEPTH;
  localparam int MAXD    = (MAXD_GL > LHT_ENTRIES) ? MAXD_GL : LHT_ENTRIES;
  localparam int SWEEP_W = $clog2(MAXD);

  localparam logic [SWEEP_W-1:0]  SWEEP_LAST = SWEEP_W'(MAXD - 1);
  localparam logic [SWEEP_W-1:0]  SWEEP_ONE  = SWEEP_W'(1);
  localparam logic [SWEEP_W:0]    GDEPTH_L   = (SWEEP_W+1)'(GDEPTH);
  localparam logic [SWEEP_W:0]    LDEPTH_L   = (SWEEP_W+1)'(LDEPTH);
  localparam logic [SWEEP_W:0]    LHTD_L     = (SWEEP_W+1)'(LHT_ENTRIES);
  // Weakly not-taken for the PHTs, weakly global for the chooser.
  localparam logic [CTR_BITS-1:0] CTR_INIT   = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  bp_tl_state_e          state_q, state_d;
  logic [SWEEP_W-1:0]    sweep_q, sweep_d;
  logic [GHIST_BITS-1:0] ghist_q, ghist_d;
  logic                  ready_s, init_s;

  logic [CTR_BITS-1:0]   gpht_q    [GDEPTH];
  logic [CTR_BITS-1:0]   chooser_q [GDEPTH];
  logic [CTR_BITS-1:0]   lpht_q    [LDEPTH];
  logic [LHIST_BITS-1:0] lht_q     [LHT_ENTRIES];

  // ---------------- lookup path (combinational, no bypass) ----------------
  logic [GHIST_BITS-1:0] req_gidx_s;
  logic [LHT_IDX-1:0]    req_lidx_s;
  logic [LHIST_BITS-1:0] req_lhist_s;
  logic [CTR_BITS-1:0]   req_gctr_s, req_lctr_s, req_cctr_s;
  logic                  pred_global_s, pred_local_s, pred_final_s;

  assign req_gidx_s    = i_req_pc[GHIST_BITS-1:0] ^ ghist_q;
  assign req_lidx_s    = i_req_pc[LHT_IDX-1:0];
  assign req_lhist_s   = lht_q[req_lidx_s];
  assign req_gctr_s    = gpht_q[req_gidx_s];
  assign req_lctr_s    = lpht_q[req_lhist_s];
  assign req_cctr_s    = chooser_q[req_gidx_s];
  assign pred_global_s = req_gctr_s[CTR_BITS-1];
  assign pred_local_s  = req_lctr_s[CTR_BITS-1];
  assign pred_final_s  = req_cctr_s[CTR_BITS-1] ? pred_local_s : pred_global_s;

  assign o_req_ready       = ready_s;
  assign o_req_prediction  = BranchOutcome'(pred_final_s);
  assign o_req_pred_global = BranchOutcome'(pred_global_s);
  assign o_req_pred_local  = BranchOutcome'(pred_local_s);
  assign o_req_ghistory    = ghist_q;
  assign o_req_lhistory    = req_lhist_s;

  // ---------------- feedback path ----------------
  logic                  req_fire_s, fb_fire_s, fb_taken_s, mispredict_s;
  logic                  chooser_upd_s, local_correct_s;
  logic [GHIST_BITS-1:0] fb_gidx_s;
  logic [LHT_IDX-1:0]    fb_lidx_s;
  logic [CTR_BITS-1:0]   g_new_s, l_new_s, c_new_s;

  assign req_fire_s      = i_req_valid & ready_s;
  assign fb_fire_s       = i_fb_valid & ready_s;
  assign fb_taken_s      = (i_fb_outcome == TAKEN);
  assign mispredict_s    = (i_fb_prediction != i_fb_outcome);
  assign chooser_upd_s   = (i_fb_pred_global != i_fb_pred_local);
  assign local_correct_s = (i_fb_pred_local == i_fb_outcome);
  assign fb_gidx_s       = i_fb_pc[GHIST_BITS-1:0] ^ i_fb_ghistory;
  assign fb_lidx_s       = i_fb_pc[LHT_IDX-1:0];

  sat_counter_update #(.CTR_BITS(CTR_BITS)) u_gctr (
    .ctr_i (gpht_q[fb_gidx_s]),
    .up_i  (fb_taken_s),
    .ctr_o (g_new_s)
  );

  sat_counter_update #(.CTR_BITS(CTR_BITS)) u_lctr (
    .ctr_i (lpht_q[i_fb_lhistory]),
    .up_i  (fb_taken_s),
    .ctr_o (l_new_s)
  );

  sat_counter_update #(.CTR_BITS(CTR_BITS)) u_cctr (
    .ctr_i (chooser_q[fb_gidx_s]),
    .up_i  (local_correct_s),
    .ctr_o (c_new_s)
  );

  // Upper PC bits take no part in indexing.
  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^{i_req_pc, i_fb_pc};

  // ---------------- controller ----------------
  // State, sweep counter and speculative global history registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ghist_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghist_q <= ghist_d;
    end
  end

  // Next state: sweep every index once, then serve lookups
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        if (sweep_q == SWEEP_LAST) begin
          state_d = ST_READY;
          sweep_d = '0;
        end else begin
          state_d = ST_INIT;
          sweep_d = sweep_q + SWEEP_ONE;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
        sweep_d = '0;
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // State decode: sweep enable and lookup ready
  always_comb begin
    ready_s = 1'b0;
    init_s  = 1'b0;
    case (state_q)
      ST_INIT:  init_s  = 1'b1;
      ST_READY: ready_s = 1'b1;
      default: begin
        ready_s = 1'b0;
        init_s  = 1'b0;
      end
    endcase
  end

  // Global history: a misprediction repair overrides the speculative shift
  always_comb begin
    ghist_d = ghist_q;
    if (fb_fire_s && mispredict_s) begin
      ghist_d = {i_fb_ghistory[GHIST_BITS-2:0], fb_taken_s};
    end else if (req_fire_s) begin
      ghist_d = {ghist_q[GHIST_BITS-2:0], pred_final_s};
    end else begin
      ghist_d = ghist_q;
    end
  end

  // Table writes: initialisation sweep, otherwise training from commits
  always_ff @(posedge clk) begin
    if (init_s) begin
      if ({1'b0, sweep_q} < GDEPTH_L) begin
        gpht_q[sweep_q[GHIST_BITS-1:0]]    <= CTR_INIT;
        chooser_q[sweep_q[GHIST_BITS-1:0]] <= CTR_INIT;
      end
      if ({1'b0, sweep_q} < LDEPTH_L) begin
        lpht_q[sweep_q[LHIST_BITS-1:0]] <= CTR_INIT;
      end
      if ({1'b0, sweep_q} < LHTD_L) begin
        lht_q[sweep_q[LHT_IDX-1:0]] <= '0;
      end
    end else if (fb_fire_s) begin
      gpht_q[fb_gidx_s]      <= g_new_s;
      lpht_q[i_fb_lhistory]  <= l_new_s;
      lht_q[fb_lidx_s]       <= {i_fb_lhistory[LHIST_BITS-2:0], fb_taken_s};
      if (chooser_upd_s) begin
        chooser_q[fb_gidx_s] <= c_new_s;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  // Saturating counts of committed and mispredicted branches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      if (fb_fire_s && (stat_br_q != 32'hFFFF_FFFF)) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (fb_fire_s && mispredict_s && (stat_mp_q != 32'hFFFF_FFFF)) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign o_stat_branches    = stat_br_q;
  assign o_stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_bp_tournament_local.sv
// Randomised scoreboard bench for bp_tournament_local with a table-level
// reference model of the tournament predictor.
module tb_bp_tournament_local;
  import mips_core_pkg::*;

  localparam int GB   = 8;
  localparam int LB   = 6;
  localparam int LHT  = 64;
  localparam int LI   = 6;
  localparam int CB   = 2;
  localparam int MAXD = 256;
  localparam int CMAX = (1 << CB) - 1;
  localparam int HALF = 1 << (CB - 1);
  localparam int WEAK = HALF - 1;

  typedef struct {
    logic [31:0] pc;
    int          gh;
    int          lh;
    bit          p;
    bit          pg;
    bit          pl;
  } info_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bp_tournament_local_if #(.GHIST_BITS(GB), .LHIST_BITS(LB)) bus ();

  bp_tournament_local #(
    .GHIST_BITS(GB), .LHIST_BITS(LB), .LHT_ENTRIES(LHT), .CTR_BITS(CB)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_req_valid       (bus.i_req_valid),
    .i_req_pc          (bus.i_req_pc),
    .o_req_ready       (bus.o_req_ready),
    .o_req_prediction  (bus.o_req_prediction),
    .o_req_pred_global (bus.o_req_pred_global),
    .o_req_pred_local  (bus.o_req_pred_local),
    .o_req_ghistory    (bus.o_req_ghistory),
    .o_req_lhistory    (bus.o_req_lhistory),
    .i_fb_valid        (bus.i_fb_valid),
    .i_fb_pc           (bus.i_fb_pc),
    .i_fb_ghistory     (bus.i_fb_ghistory),
    .i_fb_lhistory     (bus.i_fb_lhistory),
    .i_fb_prediction   (bus.i_fb_prediction),
    .i_fb_pred_global  (bus.i_fb_pred_global),
    .i_fb_pred_local   (bus.i_fb_pred_local),
    .i_fb_outcome      (bus.i_fb_outcome)
`ifdef BP_STATS_EN
    ,
    .o_stat_branches    (bus.o_stat_branches),
    .o_stat_mispredicts (bus.o_stat_mispredicts)
`endif
  );

  // ---------------- reference model ----------------
  int m_gpht [256];
  int m_cho  [256];
  int m_lpht [64];
  int m_lht  [64];
  int m_ghist;
  int m_br;
  int m_mp;

  logic [16:0] expq [$];
  info_t       pend [$];

  function automatic int sat(input int v, input bit up);
    if (up) return (v < CMAX) ? v + 1 : v;
    return (v > 0) ? v - 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_gpht[i] = WEAK;
      m_cho[i]  = WEAK;
    end
    for (int i = 0; i < 64; i++) begin
      m_lpht[i] = WEAK;
      m_lht[i]  = 0;
    end
    m_ghist = 0;
    m_br = 0;
    m_mp = 0;
    pend.delete();
  endtask

  task automatic clear_inputs();
    bus.i_req_valid      = 1'b0;
    bus.i_req_pc         = 32'h0;
    bus.i_fb_valid       = 1'b0;
    bus.i_fb_pc          = 32'h0;
    bus.i_fb_ghistory    = 8'h0;
    bus.i_fb_lhistory    = 6'h0;
    bus.i_fb_prediction  = NOT_TAKEN;
    bus.i_fb_pred_global = NOT_TAKEN;
    bus.i_fb_pred_local  = NOT_TAKEN;
    bus.i_fb_outcome     = NOT_TAKEN;
  endtask

  task automatic rand_inputs();
    bus.i_req_valid      = 1'($urandom_range(0, 1));
    bus.i_req_pc         = $urandom;
    bus.i_fb_valid       = 1'($urandom_range(0, 1));
    bus.i_fb_pc          = $urandom;
    bus.i_fb_ghistory    = 8'($urandom);
    bus.i_fb_lhistory    = 6'($urandom);
    bus.i_fb_prediction  = BranchOutcome'($urandom_range(0, 1));
    bus.i_fb_pred_global = BranchOutcome'($urandom_range(0, 1));
    bus.i_fb_pred_local  = BranchOutcome'($urandom_range(0, 1));
    bus.i_fb_outcome     = BranchOutcome'($urandom_range(0, 1));
  endtask

  // Drive one READY-state cycle and advance the model; does not wait.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit fv,
                      input info_t fi, input bit fout, output info_t cap);
    int gidx, lh, fg;
    bit pg, pl, p;
    bus.i_req_valid      = rv;
    bus.i_req_pc         = rpc;
    bus.i_fb_valid       = fv;
    bus.i_fb_pc          = fi.pc;
    bus.i_fb_ghistory    = GB'(fi.gh);
    bus.i_fb_lhistory    = LB'(fi.lh);
    bus.i_fb_prediction  = BranchOutcome'(fi.p);
    bus.i_fb_pred_global = BranchOutcome'(fi.pg);
    bus.i_fb_pred_local  = BranchOutcome'(fi.pl);
    bus.i_fb_outcome     = BranchOutcome'(fout);
    gidx = int'(rpc[GB-1:0]) ^ m_ghist;
    lh   = m_lht[int'(rpc[LI-1:0])];
    pg   = (m_gpht[gidx] >= HALF);
    pl   = (m_lpht[lh] >= HALF);
    p    = (m_cho[gidx] >= HALF) ? pl : pg;
    cap  = '{pc: rpc, gh: m_ghist, lh: lh, p: p, pg: pg, pl: pl};
    if (rv) expq.push_back({p, pg, pl, GB'(m_ghist), LB'(lh)});
    if (fv) begin
      fg = (int'(fi.pc[GB-1:0]) ^ fi.gh) & 255;
      m_gpht[fg]    = sat(m_gpht[fg], fout);
      m_lpht[fi.lh] = sat(m_lpht[fi.lh], fout);
      m_lht[int'(fi.pc[LI-1:0])] = ((fi.lh << 1) | int'(fout)) & 63;
      if (fi.pg != fi.pl) m_cho[fg] = sat(m_cho[fg], fi.pl == fout);
      m_br++;
      if (fi.p != fout) m_mp++;
    end
    if (fv && (fi.p != fout)) m_ghist = ((fi.gh << 1) | int'(fout)) & 255;
    else if (rv) m_ghist = ((m_ghist << 1) | int'(p)) & 255;
  endtask

  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit fv,
                       input info_t fi, input bit fout, output info_t cap);
    step(rv, rpc, fv, fi, fout, cap);
    @(posedge clk);
    #1;
  endtask

  // Reset, optionally re-pulse reset after pulse_at sweep cycles, then
  // measure cycles until ready while hammering the inputs.
  task automatic init_phase(input int pulse_at);
    int n;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    if (pulse_at >= 0) begin
      for (int i = 0; i < pulse_at; i++) begin
        rand_inputs();
        @(posedge clk);
        #1;
        checks++;
        if (bus.o_req_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_during_sweep idx=%0d actual=%b required=0", i, bus.o_req_ready);
        end
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.o_req_ready === 1'b1) break;
      rand_inputs();
    end
    clear_inputs();
    checks++;
    if (n != MAXD) begin
      errors++;
      $display("FAIL ready_latency actual=%0d required=%0d", n, MAXD);
    end
    model_reset();
  endtask

  // ---------------- monitor ----------------
  // Compare every accepted lookup against the oldest queued expectation
  always @(negedge clk) begin
    logic [16:0] act, e;
    if (bus.i_req_valid === 1'b1 && bus.o_req_ready === 1'b1) begin
      act = {bus.o_req_prediction, bus.o_req_pred_global, bus.o_req_pred_local,
             bus.o_req_ghistory, bus.o_req_lhistory};
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL lookup_unexpected actual=%h required=none", act);
      end else begin
        e = expq.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL lookup pc=%h actual=%h required=%h (pred,g,l,ghist,lhist)",
                   bus.i_req_pc, act, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    info_t none, cap, fi;
    logic [31:0] pool [8];
    logic [31:0] pc;
    bit rv, fv, fout;
    none = '{pc: 32'h0, gh: 0, lh: 0, p: 1'b0, pg: 1'b0, pl: 1'b0};
    for (int i = 0; i < 8; i++) pool[i] = 32'($urandom_range(0, 63)) << 2;

    // Reset release: ready after exactly MAXD cycles.
    init_phase(-1);

    // Always-taken branch at 0x40, commit after each lookup.
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 32'h40, 1'b0, none, 1'b0, cap);
      cycle(1'b0, 32'h0, 1'b1, cap, 1'b1, fi);
    end
    step(1'b1, 32'h40, 1'b0, none, 1'b0, cap);
    #1;
    checks++;
    if (bus.o_req_pred_local !== TAKEN) begin
      errors++;
      $display("FAIL trained_local actual=%b required=1", bus.o_req_pred_local);
    end
    checks++;
    if (bus.o_req_prediction !== TAKEN) begin
      errors++;
      $display("FAIL trained_final actual=%b required=1", bus.o_req_prediction);
    end
    @(posedge clk);
    #1;

    // Misprediction repair wins over a same-cycle request shift.
    fi = '{pc: 32'h40, gh: 8'hA5, lh: 5, p: 1'b1, pg: 1'b1, pl: 1'b0};
    cycle(1'b1, 32'h123, 1'b1, fi, 1'b0, cap);
    clear_inputs();
    checks++;
    if (bus.o_req_ghistory !== 8'h4A) begin
      errors++;
      $display("FAIL ghist_repair actual=%h required=4a", bus.o_req_ghistory);
    end

    // Randomised lookups with delayed commits.
    for (int c = 0; c < 700; c++) begin
      rv = ($urandom_range(0, 9) < 7);
      pc = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 7)];
      fv = (pend.size() != 0) && ($urandom_range(0, 9) < 6);
      fi = fv ? pend.pop_front() : none;
      fout = fv ? (fi.pc[4] ^ ($urandom_range(0, 4) == 0)) : 1'b0;
      cycle(rv, pc, fv, fi, fout, cap);
      if (rv) pend.push_back(cap);
    end
    clear_inputs();
    @(posedge clk);
    #1;

    // Reset from READY, then again part-way through the sweep.
    init_phase(100);
    for (int c = 0; c < 300; c++) begin
      rv = ($urandom_range(0, 9) < 8);
      pc = $urandom;
      fv = (pend.size() != 0) && ($urandom_range(0, 9) < 5);
      fi = fv ? pend.pop_front() : none;
      fout = fv ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle(rv, pc, fv, fi, fout, cap);
      if (rv) pend.push_back(cap);
    end
    clear_inputs();
    @(posedge clk);
    #1;

`ifdef BP_STATS_EN
    checks++;
    if (bus.o_stat_branches !== 32'(m_br)) begin
      errors++;
      $display("FAIL stat_branches actual=%0d required=%0d", bus.o_stat_branches, m_br);
    end
    checks++;
    if (bus.o_stat_mispredicts !== 32'(m_mp)) begin
      errors++;
      $display("FAIL stat_mispredicts actual=%0d required=%0d", bus.o_stat_mispredicts, m_mp);
    end
`endif

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL lookups_missing actual=%0d required=0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
